mem_port_arbiter: RTL and testbench

- Shares one single-port, variable-latency memory between two requesters: instruction fetch (IF) and the data access of the MEM stage.
- The data side is driven by the EX/MEM pipeline register outputs: MemRead, MemWrite, ALU result as address, rdata2 as store data.
- Sequences each access through a req/ack handshake, returns read data, and raises combinational stall signals that freeze the pipeline until the access completes.
- Fixed priority: data beats fetch.

---
 rtl/mem_port_arbiter.sv | 141 ++++++++++++++
 tb/tb_mem_port_arbiter.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one variable-latency memory port between fetch and data.
// Data beats fetch; each access is a registered req/ack handshake with a timeout.
module mem_port_arbiter #(
   parameter int DATA_W  = 32,
   parameter int CNT_W   = 8,
   parameter int TIMEOUT = 200
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              if_req,
   input  logic [DATA_W-1:0] if_addr,
   output logic [DATA_W-1:0] if_rdata,
   output logic              if_valid,
   output logic              if_stall,
   input  logic              dm_read,
   input  logic              dm_write,
   input  logic [DATA_W-1:0] dm_addr,
   input  logic [DATA_W-1:0] dm_wdata,
   output logic [DATA_W-1:0] dm_rdata,
   output logic              dm_stall,
   output logic              mem_req,
   output logic              mem_we,
   output logic [DATA_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ack,
   output logic              mem_err
);

   typedef enum logic [2:0] {IDLE, D_WAIT, D_DONE, I_WAIT, I_DONE} state_t;

   state_t            state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              mem_req_q, mem_req_d;
   logic              mem_we_q, mem_we_d;
   logic [DATA_W-1:0] mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
   logic [DATA_W-1:0] dm_rdata_q, dm_rdata_d;
   logic              if_valid_q, if_valid_d;
   logic              mem_err_q, mem_err_d;
   logic              dm_any;
   logic              timed_out;

   assign dm_any    = dm_read | dm_write;
   // The last wait cycle is the one whose counter holds TIMEOUT-1, so WAIT lasts TIMEOUT cycles.
   assign timed_out = (cnt_q == CNT_W'(TIMEOUT - 1));

   always_comb begin
      state_d     = state_q;
      cnt_d       = '0;
      mem_we_d    = mem_we_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      if_rdata_d  = if_rdata_q;
      dm_rdata_d  = dm_rdata_q;
      mem_err_d   = mem_err_q;
      case (state_q)
         IDLE: begin
            if (dm_any) begin
               mem_addr_d  = dm_addr;
               mem_wdata_d = dm_wdata;
               mem_we_d    = dm_write;
               state_d     = D_WAIT;
            end else if (if_req) begin
               mem_addr_d = if_addr;
               mem_we_d   = 1'b0;
               state_d    = I_WAIT;
            end
         end
         D_WAIT: begin
            if (mem_ack) begin
               if (!mem_we_q) dm_rdata_d = mem_rdata;
               state_d = D_DONE;
            end else if (timed_out) begin
               mem_err_d  = 1'b1;
               dm_rdata_d = '0;
               state_d    = D_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         I_WAIT: begin
            if (mem_ack) begin
               if_rdata_d = mem_rdata;
               state_d    = I_DONE;
            end else if (timed_out) begin
               mem_err_d  = 1'b1;
               if_rdata_d = '0;
               state_d    = I_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         D_DONE:  state_d = IDLE;
         I_DONE:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
      mem_req_d  = (state_d == D_WAIT) || (state_d == I_WAIT);
      if_valid_d = (state_d == I_DONE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_addr_q  <= '0;
         mem_wdata_q <= '0;
         if_rdata_q  <= '0;
         dm_rdata_q  <= '0;
         if_valid_q  <= 1'b0;
         mem_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         if_rdata_q  <= if_rdata_d;
         dm_rdata_q  <= dm_rdata_d;
         if_valid_q  <= if_valid_d;
         mem_err_q   <= mem_err_d;
      end
   end

   // Stalls release combinationally in DONE so the stage advances at the end of that cycle.
   assign dm_stall  = dm_any & (state_q != D_DONE);
   assign if_stall  = if_req & (state_q != I_DONE);
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign if_rdata  = if_rdata_q;
   assign dm_rdata  = dm_rdata_q;
   assign if_valid  = if_valid_q;
   assign mem_err   = mem_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter.
module tb_mem_port_arbiter;

   localparam int DW = 32;
   localparam int TO = 200;

   logic          clk = 1'b0;
   logic          rst;
   logic          if_req;
   logic [DW-1:0] if_addr;
   logic [DW-1:0] if_rdata;
   logic          if_valid;
   logic          if_stall;
   logic          dm_read;
   logic          dm_write;
   logic [DW-1:0] dm_addr;
   logic [DW-1:0] dm_wdata;
   logic [DW-1:0] dm_rdata;
   logic          dm_stall;
   logic          mem_req;
   logic          mem_we;
   logic [DW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ack;
   logic          mem_err;

   int tests = 0;
   int fails = 0;

   mem_port_arbiter #(.DATA_W(DW), .CNT_W(8), .TIMEOUT(TO)) dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata),
      .if_valid(if_valid), .if_stall(if_stall),
      .dm_read(dm_read), .dm_write(dm_write), .dm_addr(dm_addr),
      .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_stall(dm_stall),
      .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
      .mem_err(mem_err)
   );

   always #5 clk = ~clk;

   // Each cycle begins 1ns after the rising edge; inputs are driven, then checks run 1ns later.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; if_req = 0; if_addr = '0; dm_read = 0; dm_write = 0;
      dm_addr = '0; dm_wdata = '0; mem_rdata = '0; mem_ack = 0;
      tick(); tick();
      #1;
      tests++;
      if ({mem_req, mem_we, if_valid, mem_err, dm_stall, if_stall} !== 6'b0) begin
         fails++;
         $display("FAIL reset_ctrl: got %b want 000000",
                  {mem_req, mem_we, if_valid, mem_err, dm_stall, if_stall});
      end
      tests++;
      if ({mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         fails++;
         $display("FAIL reset_data: got %h %h %h %h want all 0", mem_addr, mem_wdata, if_rdata, dm_rdata);
      end
      tick();
      rst = 1'b0;
   endtask

   task automatic test_load();
      tick();
      dm_read = 1; dm_addr = 32'h40;
      #1;
      tests++;
      if (dm_stall !== 1'b1 || mem_req !== 1'b0) begin
         fails++; $display("FAIL load_c0: stall=%b req=%b want 1 0", dm_stall, mem_req);
      end
      tick();
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_addr !== 32'h40 || dm_stall !== 1'b1) begin
         fails++;
         $display("FAIL load_c1: req=%b we=%b addr=%h stall=%b want 1 0 40 1", mem_req, mem_we, mem_addr, dm_stall);
      end
      mem_ack = 1; mem_rdata = 32'h1234ABCD;
      tick();
      mem_ack = 0; mem_rdata = '0;
      #1;
      tests++;
      if (dm_stall !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h1234ABCD) begin
         fails++;
         $display("FAIL load_c2: stall=%b req=%b rdata=%h want 0 0 1234abcd", dm_stall, mem_req, dm_rdata);
      end
      dm_read = 0;
      tick();
      #1;
      tests++;
      if (dm_rdata !== 32'h1234ABCD || mem_req !== 1'b0) begin
         fails++; $display("FAIL load_hold: rdata=%h req=%b want 1234abcd 0", dm_rdata, mem_req);
      end
   endtask

   task automatic test_store();
      int bad = 0;
      dm_write = 1; dm_addr = 32'h80; dm_wdata = 32'hCAFEF00D;
      tick();
      for (int c = 1; c <= 3; c++) begin
         #1;
         if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h80 ||
             mem_wdata !== 32'hCAFEF00D || dm_stall !== 1'b1) bad++;
         if (c == 3) mem_ack = 1;
         tick();
      end
      mem_ack = 0;
      tests++;
      if (bad != 0) begin
         fails++; $display("FAIL store_wait: %0d bad wait cycles, want 0", bad);
      end
      #1;
      tests++;
      if (dm_stall !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== 32'h1234ABCD) begin
         fails++;
         $display("FAIL store_done: stall=%b req=%b rdata=%h want 0 0 1234abcd", dm_stall, mem_req, dm_rdata);
      end
      dm_write = 0;
      tick();
   endtask

   task automatic test_simultaneous();
      int pulses = 0;
      int stall_bad = 0;
      if_req = 1; if_addr = 32'h0; dm_read = 1; dm_addr = 32'h100;
      #1;
      if (if_stall !== 1'b1) stall_bad++;
      tick();
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h100 || mem_we !== 1'b0) begin
         fails++; $display("FAIL sim_data_first: req=%b addr=%h we=%b want 1 100 0", mem_req, mem_addr, mem_we);
      end
      if (if_stall !== 1'b1) stall_bad++;
      mem_ack = 1; mem_rdata = 32'h11111111;
      tick();
      mem_ack = 0;
      #1;
      tests++;
      if (dm_stall !== 1'b0 || dm_rdata !== 32'h11111111) begin
         fails++; $display("FAIL sim_data_done: stall=%b rdata=%h want 0 11111111", dm_stall, dm_rdata);
      end
      if (if_stall !== 1'b1) stall_bad++;
      if (if_valid === 1'b1) pulses++;
      dm_read = 0;
      tick();
      #1;
      if (if_stall !== 1'b1 || mem_req !== 1'b0) stall_bad++;
      if (if_valid === 1'b1) pulses++;
      tick();
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h0 || mem_we !== 1'b0) begin
         fails++; $display("FAIL sim_fetch_issue: req=%b addr=%h we=%b want 1 0 0", mem_req, mem_addr, mem_we);
      end
      if (if_stall !== 1'b1) stall_bad++;
      if (if_valid === 1'b1) pulses++;
      mem_ack = 1; mem_rdata = 32'h00C0FFEE;
      tick();
      mem_ack = 0; mem_rdata = '0;
      #1;
      tests++;
      if (if_stall !== 1'b0 || if_rdata !== 32'h00C0FFEE) begin
         fails++; $display("FAIL sim_fetch_done: stall=%b rdata=%h want 0 00c0ffee", if_stall, if_rdata);
      end
      if (if_valid === 1'b1) pulses++;
      if_req = 0;
      tick();
      #1;
      if (if_valid === 1'b1) pulses++;
      tick();
      #1;
      if (if_valid === 1'b1) pulses++;
      tests++;
      if (stall_bad != 0) begin
         fails++; $display("FAIL sim_if_stall: %0d cycles with if_stall low before fetch done, want 0", stall_bad);
      end
      tests++;
      if (pulses != 1) begin
         fails++; $display("FAIL sim_if_valid: %0d pulses, want 1", pulses);
      end
   endtask

   task automatic test_timeout();
      int n = 0;
      dm_read = 1; dm_addr = 32'h200;
      tick();
      #1;
      tests++;
      if (mem_err !== 1'b0 || mem_req !== 1'b1) begin
         fails++; $display("FAIL to_start: err=%b req=%b want 0 1", mem_err, mem_req);
      end
      while (mem_req === 1'b1 && n < 1000) begin
         n++;
         tick();
         #1;
      end
      tests++;
      if (n != TO) begin
         fails++; $display("FAIL to_cycles: %0d wait cycles, want %0d", n, TO);
      end
      tests++;
      if (mem_err !== 1'b1 || dm_rdata !== 32'h0 || dm_stall !== 1'b0) begin
         fails++; $display("FAIL to_done: err=%b rdata=%h stall=%b want 1 0 0", mem_err, dm_rdata, dm_stall);
      end
      dm_read = 0;
      tick(); tick(); tick();
      #1;
      tests++;
      if (mem_err !== 1'b1) begin
         fails++; $display("FAIL to_sticky: err=%b want 1", mem_err);
      end
   endtask

   task automatic test_reset_mid();
      if_req = 1; if_addr = 32'h44;
      tick();
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_addr !== 32'h44) begin
         fails++; $display("FAIL rm_fetch: req=%b addr=%h want 1 44", mem_req, mem_addr);
      end
      #1;
      rst = 1; if_req = 0;
      #1;
      tests++;
      if ({mem_req, mem_we, if_valid, mem_err, if_stall} !== 5'b0 ||
          {mem_addr, mem_wdata, if_rdata, dm_rdata} !== '0) begin
         fails++;
         $display("FAIL rm_async: req=%b we=%b v=%b err=%b addr=%h rd=%h want all 0",
                  mem_req, mem_we, if_valid, mem_err, mem_addr, if_rdata);
      end
      tick();
      rst = 0;
      mem_ack = 1; mem_rdata = 32'hBADBAD00;
      tick();
      mem_ack = 0; mem_rdata = '0;
      #1;
      tests++;
      if (if_valid !== 1'b0 || mem_req !== 1'b0 || if_rdata !== 32'h0) begin
         fails++; $display("FAIL rm_late_ack: v=%b req=%b rdata=%h want 0 0 0", if_valid, mem_req, if_rdata);
      end
      tick();
      #1;
      tests++;
      if (if_valid !== 1'b0) begin
         fails++; $display("FAIL rm_late_ack2: v=%b want 0", if_valid);
      end
   endtask

   task automatic test_spurious_rw();
      mem_ack = 1; mem_rdata = 32'hDEADBEEF;
      tick();
      mem_ack = 0; mem_rdata = '0;
      #1;
      tests++;
      if (mem_req !== 1'b0 || if_valid !== 1'b0 || dm_rdata !== 32'h0 || if_rdata !== 32'h0) begin
         fails++;
         $display("FAIL spur_ack: req=%b v=%b drd=%h ird=%h want 0 0 0 0", mem_req, if_valid, dm_rdata, if_rdata);
      end
      dm_read = 1; dm_write = 1; dm_addr = 32'h300; dm_wdata = 32'h5A5A5A5A;
      tick();
      #1;
      tests++;
      if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h300 || mem_wdata !== 32'h5A5A5A5A) begin
         fails++;
         $display("FAIL rw_write: req=%b we=%b addr=%h wd=%h want 1 1 300 5a5a5a5a", mem_req, mem_we, mem_addr, mem_wdata);
      end
      mem_ack = 1; mem_rdata = 32'h77777777;
      tick();
      mem_ack = 0; mem_rdata = '0;
      #1;
      tests++;
      if (dm_stall !== 1'b0 || dm_rdata !== 32'h0) begin
         fails++; $display("FAIL rw_done: stall=%b rdata=%h want 0 0", dm_stall, dm_rdata);
      end
      dm_read = 0; dm_write = 0;
      tick();
   endtask

   initial begin
      test_reset();
      test_load();
      test_store();
      test_simultaneous();
      test_timeout();
      test_reset_mid();
      test_spurious_rw();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
